// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b types and constants for the memory-access sequencer.
//   lc3b_word / lc3b_mem_wmask / lc3b_opcode : basic datapath types
//   lc3b_memseq_state                        : sequencer FSM encoding
//   WMASK_*                                  : byte-lane write masks
//   helper functions classify opcodes for the sequencer.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_acc1 = 2'd1,
    s_acc2 = 2'd2,
    s_done = 2'd3
  } lc3b_memseq_state;

  localparam lc3b_mem_wmask WMASK_LO   = 2'b01;
  localparam lc3b_mem_wmask WMASK_HI   = 2'b10;
  localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

  // Opcodes that touch memory at all.
  function automatic logic is_mem_op(lc3b_opcode op);
    return (op == op_ldr) || (op == op_ldb) || (op == op_str) ||
           (op == op_stb) || (op == op_ldi) || (op == op_sti);
  endfunction

  // Opcodes whose first access is a write (ldi/sti start with a pointer read).
  function automatic logic is_direct_store(lc3b_opcode op);
    return (op == op_str) || (op == op_stb);
  endfunction

  function automatic logic is_byte_op(lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

  function automatic logic is_indirect(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/lc3b_byte_lane.sv
// lc3b_byte_lane: combinational byte-lane steering for LDB/STB and word ops.
//   i_addr0      : address bit 0 (selects high/low byte)
//   i_is_byte    : current access is a byte access
//   i_store_byte : byte to store (replicated on both lanes)
//   i_store_word : word to store for word accesses
//   i_mem_rdata  : memory read data
//   o_wmask      : write mask (ungated; caller qualifies with the write strobe)
//   o_wdata      : write data
//   o_load_byte  : zero-extended byte selected by i_addr0
module lc3b_byte_lane
  import lc3b_types::*;
(
  input  logic          i_addr0,
  input  logic          i_is_byte,
  input  logic [7:0]    i_store_byte,
  input  lc3b_word      i_store_word,
  input  lc3b_word      i_mem_rdata,
  output lc3b_mem_wmask o_wmask,
  output lc3b_word      o_wdata,
  output lc3b_word      o_load_byte
);

  assign o_wmask     = i_is_byte ? (i_addr0 ? WMASK_HI : WMASK_LO) : WMASK_WORD;
  // Byte stores drive the byte on both lanes; the mask picks the one that lands.
  assign o_wdata     = i_is_byte ? {i_store_byte, i_store_byte} : i_store_word;
  assign o_load_byte = i_addr0 ? {8'h00, i_mem_rdata[15:8]} : {8'h00, i_mem_rdata[7:0]};

endmodule

// File: rtl/lc3b_mem_seq.sv
// lc3b_mem_seq: multi-cycle load/store sequencer between the LC-3b datapath
// and a mem_read/mem_write/mem_resp memory port.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_op/addr/wdata     : decoded opcode, effective address, store data
//   done, err             : one-cycle completion pulse / error pulse
//   rdata                 : last load result, held until the next load completes
//   mem_*                 : memory port; strobes held until mem_resp
// Optional build macro LC3B_MEMSEQ_TIMEOUT_EN: abort an access after
// TIMEOUT_CYCLES strobe cycles without mem_resp and report err with done.
module lc3b_mem_seq
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [15:0]   req_addr,
  input  logic [15:0]   req_wdata,
  output logic          done,
  output logic          err,
  output logic [15:0]   rdata,
  output logic [15:0]   mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [1:0]    mem_wmask,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_resp
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("lc3b_mem_seq: TIMEOUT_CYCLES must be at least 1");
  end

  lc3b_memseq_state r_state, w_state_nxt;
  lc3b_opcode       r_op;
  lc3b_word         r_addr, r_wdata, r_ptr, r_rdata;

  logic          w_accept, w_strobe, w_tmo, w_lane_byte;
  lc3b_mem_wmask w_lane_wmask;
  lc3b_word      w_lane_wdata, w_load_byte;

  assign w_accept  = req_valid && req_ready;
  assign w_strobe  = mem_read || mem_write;
  assign req_ready = (r_state == s_idle);
  assign done      = (r_state == s_done);
  assign rdata     = r_rdata;

  // Only the first access of ldb/stb is byte-wide; ldi/sti pointer and data
  // accesses are always whole words.
  assign w_lane_byte = (r_state == s_acc1) && is_byte_op(r_op);

  lc3b_byte_lane u_lane (
    .i_addr0      (r_addr[0]),
    .i_is_byte    (w_lane_byte),
    .i_store_byte (r_wdata[7:0]),
    .i_store_word (r_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_wmask      (w_lane_wmask),
    .o_wdata      (w_lane_wdata),
    .o_load_byte  (w_load_byte)
  );

`ifdef LC3B_MEMSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Any state change restarts the count, so each access gets a fresh budget.
  always_ff @(posedge clk) begin
    if (reset || (w_state_nxt != r_state)) r_cnt <= '0;
    else if (w_strobe)                     r_cnt <= r_cnt + CNT_W'(1);
  end

  // A response in the final allowed cycle still wins over the timeout.
  assign w_tmo = w_strobe && !mem_resp && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Set on the edge into DONE via timeout, so it lines up with done.
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_tmo;
  end
  assign err = r_err;
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= s_idle;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; mem_resp is only looked at while a strobe is up.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      s_idle: if (w_accept)
                w_state_nxt = is_mem_op(lc3b_opcode'(req_op)) ? s_acc1 : s_done;
      s_acc1: if (mem_resp)   w_state_nxt = is_indirect(r_op) ? s_acc2 : s_done;
              else if (w_tmo) w_state_nxt = s_done;
      s_acc2: if (mem_resp || w_tmo) w_state_nxt = s_done;
      s_done: w_state_nxt = s_idle;
      default: w_state_nxt = s_idle;
    endcase
  end

  // Memory port outputs, decoded from state so strobes fall on the same edge
  // that samples mem_resp (or reset).
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    unique case (r_state)
      s_acc1: begin
        mem_address = is_byte_op(r_op) ? r_addr : {r_addr[15:1], 1'b0};
        mem_write   = is_direct_store(r_op);
        mem_read    = !is_direct_store(r_op);
      end
      s_acc2: begin
        mem_address = {r_ptr[15:1], 1'b0};
        mem_write   = (r_op == op_sti);
        mem_read    = (r_op != op_sti);
      end
      default: ;
    endcase
    mem_wmask = mem_write ? w_lane_wmask : '0;
    mem_wdata = mem_write ? w_lane_wdata : '0;
  end

  // Request latch, pointer and load-result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= op_br;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ptr   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= lc3b_opcode'(req_op);
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if ((r_state == s_acc1) && mem_resp) begin
        if (is_indirect(r_op))   r_ptr   <= mem_rdata;
        else if (r_op == op_ldr) r_rdata <= mem_rdata;
        else if (r_op == op_ldb) r_rdata <= w_load_byte;
      end
      if ((r_state == s_acc2) && mem_resp && (r_op == op_ldi))
        r_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lc3b_mem_seq.sv
// tb_lc3b_mem_seq: directed test of lc3b_mem_seq against a small memory
// responder with programmable wait states and hand-computed expectations.
module tb_lc3b_mem_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic        done, err;
  logic [15:0] rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_wmask;

  lc3b_mem_seq #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Memory responder: answers after wait_cfg strobe cycles.
  int          wait_cfg = 0;
  logic        resp_en = 1'b1, resp_force = 1'b0;
  logic [7:0]  wcnt = '0;
  logic [15:0] tbl_a [4];
  logic [15:0] tbl_d [4];

  assign mem_resp = ((mem_read || mem_write) && resp_en && (int'(wcnt) == wait_cfg))
                    || resp_force;

  always @(posedge clk)
    if ((mem_read || mem_write) && !mem_resp) wcnt <= wcnt + 8'd1;
    else                                      wcnt <= '0;

  always_comb begin
    mem_rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++)
      if (tbl_a[i][15:1] == mem_address[15:1]) mem_rdata = tbl_d[i];
  end

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-request observations
  int          m_rd, m_wr, m_dn, m_dn_at, m_both;
  logic        m_err, m_rdy_after, m_fin;
  logic [15:0] m_rd_first, m_rd_last, m_wr_addr, m_wr_data;
  logic [1:0]  m_wr_mask;

  // Called at a negedge with the DUT idle; returns at a negedge two cycles after done.
  task automatic run_req(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] wd);
    int k;
    m_rd = 0; m_wr = 0; m_dn = 0; m_dn_at = 0; m_both = 0;
    m_err = 1'b0; m_rdy_after = 1'b0; m_fin = 1'b0;
    m_rd_first = '0; m_rd_last = '0; m_wr_addr = '0; m_wr_data = '0; m_wr_mask = '0;
    chk("ready_before", 32'(req_ready), 'h1);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!m_fin && k <= 40) begin
      if (mem_read && mem_write) m_both++;
      if (mem_read) begin
        if (m_rd == 0) m_rd_first = mem_address;
        m_rd_last = mem_address;
        m_rd++;
      end
      if (mem_write) begin
        m_wr++; m_wr_addr = mem_address; m_wr_data = mem_wdata; m_wr_mask = mem_wmask;
      end
      if (m_dn_at != 0 && k == m_dn_at + 1) m_rdy_after = req_ready;
      if (done) begin
        m_dn++;
        if (m_dn_at == 0) begin m_dn_at = k; m_err = err; end
      end
      if (m_dn_at != 0 && k == m_dn_at + 2) m_fin = 1'b1;
      k++;
      @(negedge clk);
    end
    chk("done_seen", 32'(m_fin), 'h1);
  endtask

  task automatic chk_req(input string t, input int dn_at, input int rd, input int wr,
                         input logic exp_err);
    chk({t, "_done_at"}, 32'(m_dn_at), 32'(dn_at));
    chk({t, "_done_cnt"}, 32'(m_dn), 'h1);
    chk({t, "_rd_cyc"}, 32'(m_rd), 32'(rd));
    chk({t, "_wr_cyc"}, 32'(m_wr), 32'(wr));
    chk({t, "_both"}, 32'(m_both), 'h0);
    chk({t, "_err"}, 32'(m_err), 32'(exp_err));
    chk({t, "_rdy_after"}, 32'(m_rdy_after), 'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl_a[0] = 16'h3004; tbl_d[0] = 16'hBEEF;
    tbl_a[1] = 16'h2000; tbl_d[1] = 16'h80FF;
    tbl_a[2] = 16'h4000; tbl_d[2] = 16'h5003;
    tbl_a[3] = 16'h5002; tbl_d[3] = 16'h7777;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_ready", 32'(req_ready), 'h1);
    chk("rst_done",  32'(done), 'h0);
    chk("rst_err",   32'(err), 'h0);
    chk("rst_rdata", 32'(rdata), 'h0);
    chk("rst_strb",  32'({mem_read, mem_write}), 'h0);
    chk("rst_wmask", 32'(mem_wmask), 'h0);
    chk("rst_addr",  32'(mem_address), 'h0);
    chk("rst_wdata", 32'(mem_wdata), 'h0);

    // LDR, 2 wait states
    wait_cfg = 2;
    run_req(4'b0110, 16'h3005, 16'h0);
    chk_req("ldr", 4, 3, 0, 1'b0);
    chk("ldr_addr", 32'(m_rd_first), 'h3004);
    chk("ldr_rdata", 32'(rdata), 'hBEEF);

    // STB high byte, zero wait
    wait_cfg = 0;
    run_req(4'b0011, 16'h1001, 16'h12A5);
    chk_req("stb", 2, 0, 1, 1'b0);
    chk("stb_addr", 32'(m_wr_addr), 'h1001);
    chk("stb_mask", 32'(m_wr_mask), 'h2);
    chk("stb_data", 32'(m_wr_data), 'hA5A5);
    chk("stb_rdata_kept", 32'(rdata), 'hBEEF);

    // LDB low then high byte
    run_req(4'b0010, 16'h2000, 16'h0);
    chk_req("ldb0", 2, 1, 0, 1'b0);
    chk("ldb0_addr", 32'(m_rd_first), 'h2000);
    chk("ldb0_rdata", 32'(rdata), 'h00FF);
    run_req(4'b0010, 16'h2001, 16'h0);
    chk_req("ldb1", 2, 1, 0, 1'b0);
    chk("ldb1_addr", 32'(m_rd_first), 'h2001);
    chk("ldb1_rdata", 32'(rdata), 'h0080);

    // STI through pointer 0x5003
    run_req(4'b1011, 16'h4000, 16'h1234);
    chk_req("sti", 3, 1, 1, 1'b0);
    chk("sti_ptr_addr", 32'(m_rd_first), 'h4000);
    chk("sti_addr", 32'(m_wr_addr), 'h5002);
    chk("sti_mask", 32'(m_wr_mask), 'h3);
    chk("sti_data", 32'(m_wr_data), 'h1234);
    chk("sti_rdata_kept", 32'(rdata), 'h0080);

    // LDI through pointer 0x5003
    run_req(4'b1010, 16'h4001, 16'h0);
    chk_req("ldi", 3, 2, 0, 1'b0);
    chk("ldi_ptr_addr", 32'(m_rd_first), 'h4000);
    chk("ldi_addr", 32'(m_rd_last), 'h5002);
    chk("ldi_rdata", 32'(rdata), 'h7777);

    // STR at odd address aligns down
    run_req(4'b0111, 16'h6001, 16'hCAFE);
    chk_req("str", 2, 0, 1, 1'b0);
    chk("str_addr", 32'(m_wr_addr), 'h6000);
    chk("str_mask", 32'(m_wr_mask), 'h3);
    chk("str_data", 32'(m_wr_data), 'hCAFE);

    // Non-memory opcode: straight to DONE
    run_req(4'b0001, 16'h3004, 16'hFFFF);
    chk_req("add", 1, 0, 0, 1'b0);
    chk("add_rdata_kept", 32'(rdata), 'h7777);

    // Reset during ACC2 of an LDI
    wait_cfg = 3;
    req_op = 4'b1010; req_addr = 16'h4000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_acc2_rd", 32'(mem_read), 'h1);
    chk("rstmid_acc2_addr", 32'(mem_address), 'h5002);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_strb", 32'({mem_read, mem_write}), 'h0);
    chk("rstmid_rdata", 32'(rdata), 'h0);
    reset = 1'b0;
    chk("rstmid_ready", 32'(req_ready), 'h1);
    resp_force = 1'b1;
    @(negedge clk);
    resp_force = 1'b0;
    m_dn = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) m_dn++;
      @(negedge clk);
    end
    chk("rstmid_no_done", 32'(m_dn), 'h0);
    chk("rstmid_ready2", 32'(req_ready), 'h1);
    chk("rstmid_rdata2", 32'(rdata), 'h0);

    // Recovery after reset
    wait_cfg = 0;
    run_req(4'b0010, 16'h2001, 16'h0);
    chk_req("rec", 2, 1, 0, 1'b0);
    chk("rec_rdata", 32'(rdata), 'h0080);

`ifdef LC3B_MEMSEQ_TIMEOUT_EN
    // No response: abort after 4 strobe cycles with err
    resp_en = 1'b0;
    run_req(4'b0110, 16'h3005, 16'h0);
    chk_req("tmo", 5, 4, 0, 1'b1);
    chk("tmo_rdata_kept", 32'(rdata), 'h0080);
    resp_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
